// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
// SDRAM_ARB_TIMEOUT_EN enables the WAIT timeout abort in sdram_arbiter.
package sdram_arb_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 8;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic              wren;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_cmd_t;

endpackage

// File: rtl/sdram_arb_slot.sv
// Per-port capture slot: latches one command and holds busy until cleared.
module sdram_arb_slot
    import sdram_arb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_request,
    input  logic              i_wren,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_clear,
    output logic              o_busy,
    output mem_cmd_t          o_cmd
);

    logic     busy_q, busy_d;
    mem_cmd_t cmd_q, cmd_d;

    always_comb begin
        busy_d = busy_q;
        cmd_d  = cmd_q;
        if (i_clear) begin
            busy_d = 1'b0;
        end else if (i_request && !busy_q) begin
            busy_d = 1'b1;
            cmd_d  = '{wren: i_wren, addr: i_address, data: i_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= 1'b0;
            cmd_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cmd_q  <= cmd_d;
        end
    end

    assign o_busy = busy_q;
    assign o_cmd  = cmd_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter between fetch (p0) and data (p1) ports for one SDRAM controller.
// Define SDRAM_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES with o_P_err.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_p0_request,
    input  logic              i_p0_wren,
    input  logic [ADDR_W-1:0] i_p0_address,
    input  logic [DATA_W-1:0] i_p0_data,
    output logic [DATA_W-1:0] o_p0_data,
    output logic              o_p0_done,
    output logic              o_p0_busy,
    output logic              o_p0_err,
    input  logic              i_p1_request,
    input  logic              i_p1_wren,
    input  logic [ADDR_W-1:0] i_p1_address,
    input  logic [DATA_W-1:0] i_p1_data,
    output logic [DATA_W-1:0] o_p1_data,
    output logic              o_p1_done,
    output logic              o_p1_busy,
    output logic              o_p1_err,
    output logic              o_mem_request,
    output logic              o_mem_wren,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_data,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic              i_mem_done
);

    logic [1:0] busy;
    logic [1:0] clear;
    mem_cmd_t   cmd [2];

    sdram_arb_slot u_slot0 (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_request (i_p0_request),
        .i_wren    (i_p0_wren),
        .i_address (i_p0_address),
        .i_data    (i_p0_data),
        .i_clear   (clear[P0]),
        .o_busy    (busy[P0]),
        .o_cmd     (cmd[P0])
    );

    sdram_arb_slot u_slot1 (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_request (i_p1_request),
        .i_wren    (i_p1_wren),
        .i_address (i_p1_address),
        .i_data    (i_p1_data),
        .i_clear   (clear[P1]),
        .o_busy    (busy[P1]),
        .o_cmd     (cmd[P1])
    );

    arb_state_e        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_q, last_d;
    logic              mem_req_q, mem_req_d;
    mem_cmd_t          mem_cmd_q, mem_cmd_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_d [2];

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        mem_req_d = 1'b0;
        mem_cmd_d = mem_cmd_q;
        done_d    = 2'b00;
        err_d     = 2'b00;
        rdata_d   = rdata_q;
        clear     = 2'b00;
`ifdef SDRAM_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (&busy) begin
                    gnt_d = ~last_q;
                end else if (busy[P0]) begin
                    gnt_d = P0;
                end else if (busy[P1]) begin
                    gnt_d = P1;
                end
                if (|busy) begin
                    state_d = ST_ISSUE;
                    last_d  = gnt_d;
                end
            end
            ST_ISSUE: begin
                mem_req_d = 1'b1;
                mem_cmd_d = cmd[gnt_q];
                state_d   = ST_WAIT;
`ifdef SDRAM_ARB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ST_WAIT: begin
                if (i_mem_done) begin
                    done_d[gnt_q] = 1'b1;
                    clear[gnt_q]  = 1'b1;
                    state_d       = ST_IDLE;
                    if (!mem_cmd_q.wren) begin
                        rdata_d[gnt_q] = i_mem_data;
                    end
                end
`ifdef SDRAM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    done_d[gnt_q] = 1'b1;
                    err_d[gnt_q]  = 1'b1;
                    clear[gnt_q]  = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= P0;
            last_q     <= P1;
            mem_req_q  <= 1'b0;
            mem_cmd_q  <= '0;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            mem_req_q  <= mem_req_d;
            mem_cmd_q  <= mem_cmd_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
        end
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign o_p0_data     = rdata_q[0];
    assign o_p1_data     = rdata_q[1];
    assign o_p0_done     = done_q[P0];
    assign o_p1_done     = done_q[P1];
    assign o_p0_err      = err_q[P0];
    assign o_p1_err      = err_q[P1];
    assign o_p0_busy     = busy[P0];
    assign o_p1_busy     = busy[P1];
    assign o_mem_request = mem_req_q;
    assign o_mem_wren    = mem_cmd_q.wren;
    assign o_mem_address = mem_cmd_q.addr;
    assign o_mem_data    = mem_cmd_q.data;

endmodule
